// File: rtl/text_framebuffer.sv
// ============================================================================
// Module   : text_framebuffer
// Brief    : COLS x ROWS byte text page with registered video read port,
//            acknowledged CPU port, hardware clear sequencer and phi divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_framebuffer #(
    parameter int          COLS    = 40,
    parameter int          ROWS    = 24,
    parameter logic [15:0] BASE    = 16'h0400,
    parameter logic [7:0]  FILL    = 8'hA0,
    parameter int          PHI_DIV = 512
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic        phi,
    output logic        phi_stb,
    input  logic [15:0] vid_adr,
    output logic [7:0]  vid_data,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        clr_req,
    output logic        busy
);

    localparam int              c_DEPTH   = COLS * ROWS;
    localparam int              c_AW      = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int              c_CW      = $clog2(PHI_DIV);
    localparam logic [15:0]     c_DEPTH16 = 16'(c_DEPTH);
    localparam logic [c_AW-1:0] c_LAST    = c_AW'(c_DEPTH - 1);
    localparam logic [c_CW-1:0] c_RELOAD  = c_CW'(PHI_DIV - 1);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;

    logic [7:0]      r_mem [c_DEPTH];
    logic [0:0]      r_state;
    logic [c_AW-1:0] r_ptr;
    logic [c_CW-1:0] r_cnt;
    logic            r_phi;
    logic            r_phi_stb;
    logic            r_ack;
    logic [7:0]      r_vid;
    logic [7:0]      r_rdata;

    logic [15:0]     w_vid_idx;
    logic [15:0]     w_cpu_idx;
    logic            w_vid_hit;
    logic            w_cpu_hit;
    logic            w_accept;
    logic            w_we;
    logic [c_AW-1:0] w_wadr;
    logic [7:0]      w_wdata;

    // Below-BASE addresses wrap to large indices and therefore miss.
    assign w_vid_idx = vid_adr - BASE;
    assign w_cpu_idx = cpu_adr - BASE;
    assign w_vid_hit = (w_vid_idx < c_DEPTH16);
    assign w_cpu_hit = (w_cpu_idx < c_DEPTH16);

    // A pending clear outranks the CPU; the ack cycle blocks back-to-back accepts.
    assign w_accept = (r_state == c_ST_IDLE) && !clr_req && !r_ack && (cpu_we || cpu_rd);

    always_comb begin
        w_we    = 1'b0;
        w_wadr  = r_ptr;
        w_wdata = FILL;
        if (!reset) begin
            if (r_state == c_ST_CLEAR) begin
                w_we = 1'b1;
            end else if (w_accept && cpu_we && w_cpu_hit) begin
                w_we    = 1'b1;
                w_wadr  = w_cpu_idx[c_AW-1:0];
                w_wdata = cpu_wdata;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_we) begin
            r_mem[w_wadr] <= w_wdata;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= c_ST_CLEAR;
            r_ptr   <= '0;
            r_ack   <= 1'b0;
            r_rdata <= 8'h00;
            r_vid   <= FILL;
        end else begin
            r_vid <= ((r_state == c_ST_CLEAR) || !w_vid_hit) ? FILL : r_mem[w_vid_idx[c_AW-1:0]];
            r_ack <= w_accept;
            if (w_accept) begin
                r_rdata <= w_cpu_hit ? r_mem[w_cpu_idx[c_AW-1:0]] : FILL;
            end
            case (r_state)
                c_ST_CLEAR: begin
                    if (r_ptr == c_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + c_AW'(1);
                    end
                end
                default: begin
                    if (clr_req) begin
                        r_state <= c_ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_cnt     <= c_RELOAD;
            r_phi     <= 1'b0;
            r_phi_stb <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt     <= c_RELOAD;
            r_phi     <= ~r_phi;
            r_phi_stb <= ~r_phi;
        end else begin
            r_cnt     <= r_cnt - c_CW'(1);
            r_phi_stb <= 1'b0;
        end
    end

    assign phi       = r_phi;
    assign phi_stb   = r_phi_stb;
    assign vid_data  = r_vid;
    assign cpu_rdata = r_rdata;
    assign cpu_ack   = r_ack;
    assign busy      = (r_state == c_ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_text_framebuffer.sv
// ============================================================================
// Module   : tb_text_framebuffer
// Brief    : Directed self-checking bench for text_framebuffer (PHI_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_framebuffer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        phi;
    logic        phi_stb;
    logic [15:0] vid_adr;
    logic [7:0]  vid_data;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_rd;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        clr_req;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    text_framebuffer #(
        .COLS    (40),
        .ROWS    (24),
        .BASE    (16'h0400),
        .FILL    (8'hA0),
        .PHI_DIV (4)
    ) u_dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .phi       (phi),
        .phi_stb   (phi_stb),
        .vid_adr   (vid_adr),
        .vid_data  (vid_data),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_rd    (cpu_rd),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts edges from reset release/clear start until busy drops; phi model assumes reset release.
    task automatic wait_clear(input string tag, input bit phi_chk);
        int first_low;
        first_low = -1;
        for (int n = 1; n <= 2000; n++) begin
            tick;
            if (phi_chk) begin
                check("phi", 32'(phi), 32'(((n / 4) % 2) == 1));
                check("phi_stb", 32'(phi_stb), 32'((n % 8) == 4));
            end
            if (!busy) begin
                first_low = n;
                break;
            end
        end
        check(tag, 32'(first_low), 32'd960);
    endtask

    task automatic cpu_xfer(input string tag, input logic we, input logic rd,
                            input logic [15:0] adr, input logic [7:0] wdata,
                            output logic [7:0] rdata);
        int lat;
        lat       = -1;
        cpu_adr   = adr;
        cpu_wdata = wdata;
        cpu_we    = we;
        cpu_rd    = rd;
        for (int n = 1; n <= 3000; n++) begin
            tick;
            if (cpu_ack) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'd1);
        rdata  = cpu_rdata;
        cpu_we = 1'b0;
        cpu_rd = 1'b0;
        tick;
        check({tag, "_ackdrop"}, 32'(cpu_ack), 32'd0);
    endtask

    logic [7:0] rd_val;
    logic [7:0] hello [11];

    initial begin
        int busy_cnt;
        int fall_m;
        int ack_m;
        int bad_ack;

        hello = '{8'h08, 8'h05, 8'h0C, 8'h0C, 8'h0F, 8'hE0, 8'h17, 8'h0F, 8'h12, 8'h0C, 8'h04};
        reset     = 1'b1;
        vid_adr   = 16'h0000;
        cpu_adr   = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_we    = 1'b0;
        cpu_rd    = 1'b0;
        clr_req   = 1'b0;
        tick;
        tick;
        check("rst_phi", 32'(phi), 32'd0);
        check("rst_phi_stb", 32'(phi_stb), 32'd0);
        check("rst_vid_data", 32'(vid_data), 32'hA0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        reset = 1'b0;
        wait_clear("init_clear_len", 1'b1);

        // Whole page reads blank after the power-up clear.
        for (int a = 16'h0400; a <= 16'h07BF; a++) begin
            vid_adr = 16'(a);
            tick;
            check("vid_blank", 32'(vid_data), 32'hA0);
        end

        for (int i = 0; i < 11; i++) begin
            cpu_xfer("hello_wr", 1'b1, 1'b0, 16'h040F + 16'(i), hello[i], rd_val);
        end
        cpu_xfer("rd_0410", 1'b0, 1'b1, 16'h0410, 8'h00, rd_val);
        check("rd_0410_data", 32'(rd_val), 32'h05);
        cpu_xfer("rd_0419", 1'b0, 1'b1, 16'h0419, 8'h00, rd_val);
        check("rd_0419_data", 32'(rd_val), 32'h04);
        cpu_xfer("rd_miss_hi", 1'b0, 1'b1, 16'h07C0, 8'h00, rd_val);
        check("rd_miss_hi_data", 32'(rd_val), 32'hA0);
        cpu_xfer("rd_miss_lo", 1'b0, 1'b1, 16'h03FF, 8'h00, rd_val);
        check("rd_miss_lo_data", 32'(rd_val), 32'hA0);
        cpu_xfer("wr_miss", 1'b1, 1'b0, 16'h03FF, 8'h99, rd_val);
        cpu_xfer("rd_after_miss", 1'b0, 1'b1, 16'h03FF, 8'h00, rd_val);
        check("rd_after_miss_data", 32'(rd_val), 32'hA0);
        cpu_xfer("rd_cell0", 1'b0, 1'b1, 16'h0400, 8'h00, rd_val);
        check("rd_cell0_data", 32'(rd_val), 32'hA0);

        cpu_xfer("wr_3c", 1'b1, 1'b0, 16'h0400, 8'h3C, rd_val);
        vid_adr = 16'h0400;
        tick;
        check("vid_0400", 32'(vid_data), 32'h3C);
        vid_adr = 16'h03FF;
        tick;
        check("vid_03ff", 32'(vid_data), 32'hA0);
        vid_adr = 16'h07C0;
        tick;
        check("vid_07c0", 32'(vid_data), 32'hA0);
        vid_adr = 16'h040F;
        tick;
        check("vid_040f", 32'(vid_data), 32'h08);

        // CPU write and video read of the same cell in one cycle.
        vid_adr   = 16'h0405;
        cpu_adr   = 16'h0405;
        cpu_wdata = 8'h41;
        cpu_we    = 1'b1;
        tick;
        check("same_cyc_ack", 32'(cpu_ack), 32'd1);
        check("same_cyc_old", 32'(vid_data), 32'hA0);
        cpu_we = 1'b0;
        tick;
        check("same_cyc_new", 32'(vid_data), 32'h41);

        cpu_xfer("rdwr", 1'b1, 1'b1, 16'h0410, 8'h55, rd_val);
        check("rdwr_old", 32'(rd_val), 32'h05);
        cpu_xfer("rd_new", 1'b0, 1'b1, 16'h0410, 8'h00, rd_val);
        check("rd_new_data", 32'(rd_val), 32'h55);

        // Clear requested with a write pending in the same cycle; the write stalls.
        cpu_xfer("wr_last", 1'b1, 1'b0, 16'h07BF, 8'h5A, rd_val);
        vid_adr   = 16'h07BF;
        tick;
        check("vid_last", 32'(vid_data), 32'h5A);
        clr_req   = 1'b1;
        cpu_adr   = 16'h0420;
        cpu_wdata = 8'h77;
        cpu_we    = 1'b1;
        tick;
        clr_req = 1'b0;
        check("clr_ack_blocked", 32'(cpu_ack), 32'd0);
        busy_cnt = busy ? 1 : 0;
        fall_m   = -1;
        ack_m    = -1;
        bad_ack  = 0;
        for (int m = 1; m <= 3000; m++) begin
            tick;
            if (cpu_ack && busy) bad_ack++;
            if (m == 100) check("vid_busy_fill", 32'(vid_data), 32'hA0);
            if (busy) busy_cnt++;
            else if (fall_m < 0) fall_m = m;
            if (cpu_ack) begin
                ack_m = m;
                break;
            end
        end
        cpu_we = 1'b0;
        check("clr_busy_len", 32'(busy_cnt), 32'd960);
        check("clr_ack_while_busy", 32'(bad_ack), 32'd0);
        check("clr_ack_after_fall", 32'(ack_m), 32'(fall_m + 1));
        tick;
        cpu_xfer("rd_stalled_wr", 1'b0, 1'b1, 16'h0420, 8'h00, rd_val);
        check("rd_stalled_wr_data", 32'(rd_val), 32'h77);
        cpu_xfer("rd_cleared", 1'b0, 1'b1, 16'h0410, 8'h00, rd_val);
        check("rd_cleared_data", 32'(rd_val), 32'hA0);

        // Reset in the middle of a clear restarts the full sequence.
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        for (int m = 0; m < 500; m++) tick;
        check("mid_clear_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        wait_clear("restart_clear_len", 1'b1);
        cpu_xfer("rd_after_restart", 1'b0, 1'b1, 16'h0420, 8'h00, rd_val);
        check("rd_after_restart_data", 32'(rd_val), 32'hA0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
